// File: rtl/stream_serializer.sv
// Parallel-to-serial converter with a one-word hold register in front of the
// shifter. Bits leave LSB first. A word waiting in the hold register is
// reloaded into the shifter on the same edge the previous word's last bit
// retires, so a steady supply of words gives an unbroken serial_valid stream.
module stream_serializer #(
  parameter int   DATA_BITS  = 10,
  parameter logic IDLE_VALUE = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic [DATA_BITS-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 serial_out,
  output logic                 serial_valid,
  output logic                 word_done,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic accept;
  logic last_bit;

  // Handshake and status decode, all from registered state only.
  assign word_ready   = !hold_full_q;
  assign accept       = word_valid && !hold_full_q;
  assign last_bit     = (cnt_q == LAST_BIT);
  assign serial_valid = (state_q == ST_SHIFT);
  assign serial_out   = serial_valid ? shift_q[0] : IDLE_VALUE;
  assign word_done    = serial_valid && last_bit;
  assign busy         = hold_full_q || serial_valid;

  // Next-state logic: clear wins over everything; otherwise an accept fills
  // the hold register while the shifter loads, shifts or reloads. Accept and
  // reload never coincide since one needs the hold empty and the other full.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;

    if (clear) begin
      hold_full_d = 1'b0;
      state_d     = ST_IDLE;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        hold_d      = word_in;
        hold_full_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers; reset abandons any word in flight immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer with hand-computed serial streams.
module tb_stream_serializer;

  localparam int DB = 10;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          n_rst = 1'b1;
  logic          clear = 1'b0;
  logic [DB-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          serial_out;
  logic          serial_valid;
  logic          word_done;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [DB-1:0] wa, wb;

  stream_serializer #(.DATA_BITS(DB), .IDLE_VALUE(1'b1)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .word_done    (word_done),
    .busy         (busy)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic so, input logic sv,
                         input logic wd, input logic wr, input logic bz);
    chk({tag, ".serial_out"},   serial_out,   so);
    chk({tag, ".serial_valid"}, serial_valid, sv);
    chk({tag, ".word_done"},    word_done,    wd);
    chk({tag, ".word_ready"},   word_ready,   wr);
    chk({tag, ".busy"},         busy,         bz);
  endtask

  // Expects the shifter to have just loaded w; checks its ten bits LSB first.
  task automatic run_word(input string tag, input logic [DB-1:0] w);
    for (int i = 0; i < DB; i++) begin
      chk($sformatf("%s.bit%0d", tag, i), serial_out, w[i]);
      chk($sformatf("%s.sv%0d", tag, i), serial_valid, 1'b1);
      chk($sformatf("%s.done%0d", tag, i), word_done, (i == DB - 1));
      tick();
    end
  endtask

  initial begin
    // Reset with no clock running.
    #3 n_rst = 1'b0;
    #1 chk_out("rst_async", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clk_en = 1'b1;
    tick();
    tick();
    chk_out("rst_held", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_rst = 1'b1;
    chk_out("rst_release", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single word accepted on the first edge after release.
    wa = 10'b1011011011;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk_out("single_accept", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    run_word("single", wa);
    chk_out("single_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back words with valid held high.
    wa = 10'b0110110110;
    wb = 10'b1101101100;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_in = wb;
    tick();
    for (int i = 0; i < 2 * DB; i++) begin
      chk($sformatf("b2b.bit%0d", i), serial_out, (i < DB) ? wa[i] : wb[i-DB]);
      chk($sformatf("b2b.sv%0d", i), serial_valid, 1'b1);
      chk($sformatf("b2b.done%0d", i), word_done, (i == DB - 1) || (i == 2 * DB - 1));
      chk($sformatf("b2b.ready%0d", i), word_ready, !(i >= 1 && i <= DB - 1));
      tick();
      if (i == 0) word_valid = 1'b0;
    end
    chk_out("b2b_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: word_in wiggles while the hold register is full.
    wa = 10'b1110001010;
    wb = 10'b0001110101;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_in = wb;
    tick();
    for (int i = 0; i < 2 * DB; i++) begin
      chk($sformatf("bp.bit%0d", i), serial_out, (i < DB) ? wa[i] : wb[i-DB]);
      chk($sformatf("bp.ready%0d", i), word_ready, !(i >= 1 && i <= DB - 1));
      tick();
      if (i < DB - 2) begin
        word_in = (i % 2 == 0) ? 10'b1111111111 : 10'b0000000000;
        word_valid = 1'b1;
      end else begin
        word_valid = 1'b0;
      end
    end
    chk_out("bp_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear at bit 4 with the hold register full.
    wa = 10'b1010101010;
    wb = 10'b0111100001;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_in = wb;
    tick();
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("clr.bit4", serial_out, wa[4]);
    chk("clr.hold_full", word_ready, 1'b0);
    clear = 1'b1;
    word_valid = 1'b1;
    word_in = 10'b1100110011;
    tick();
    clear = 1'b0;
    word_valid = 1'b0;
    chk_out("clr_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("clr_idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wa = 10'b0011001101;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    run_word("clr_next", wa);
    chk_out("clr_next_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word at bit 6.
    wa = 10'b1001110010;
    word_in = wa;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("rstmid.bit6", serial_out, wa[6]);
    chk("rstmid.sv6", serial_valid, 1'b1);
    #2 n_rst = 1'b0;
    #1 chk_out("rstmid_async", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("rstmid_held", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_rst = 1'b1;
    tick();
    chk_out("rstmid_noresume", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wb = 10'b0101100111;
    word_in = wb;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    run_word("rstmid_next", wb);
    chk_out("rstmid_next_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
